// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: fixed-latency HI/LO writeback with pipeline stall.
// The 64-bit result is computed when the operation is accepted and kept in shadow
// registers. It is copied into HI/LO only when the busy countdown expires.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_IsMD,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut,
  output logic        MD_Stall
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = ($clog2(MAXC + 1) < 4) ? 4 : $clog2(MAXC + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;

  logic               is_mul, is_md;
  logic signed [63:0] a_sx, b_sx, prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] b_safe;
  logic signed [31:0] q_s, r_s;
  logic        [31:0] q_u, r_u;
  logic        [63:0] result;

  // Full 64-bit result for the op currently presented; divide by zero keeps HI/LO.
  always_comb begin
    a_sx   = {{32{A[31]}}, A};
    b_sx   = {{32{B[31]}}, B};
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, A} * {32'd0, B};
    b_safe = (B != 32'd0) ? B : 32'd1;
    q_s    = $signed(A) / $signed(b_safe);
    r_s    = $signed(A) % $signed(b_safe);
    q_u    = A / b_safe;
    r_u    = A % b_safe;
    result = {hi_q, lo_q};
    case (MDUop)
      4'd1: result = prod_s;
      4'd2: result = prod_u;
      4'd3: if (B != 32'd0) result = {r_s, q_s};
      4'd4: if (B != 32'd0) result = {r_u, q_u};
      default: result = {hi_q, lo_q};
    endcase
  end

  // Handshake outputs depend only on registered state and current inputs.
  always_comb begin
    is_mul   = (MDUop == 4'd1) || (MDUop == 4'd2);
    is_md    = (MDUop >= 4'd1) && (MDUop <= 4'd4);
    Busy     = (state_q == RUN);
    Start    = is_md && (state_q == IDLE);
    MD_Stall = D_IsMD && (Start || Busy);
    HI       = hi_q;
    LO       = lo_q;
    case (MDUop)
      4'd7:    MDUOut = hi_q;
      4'd8:    MDUOut = lo_q;
      default: MDUOut = 32'd0;
    endcase
  end

  // Next state: accept ops and moves in IDLE; count down and commit in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          sh_hi_d = result[63:32];
          sh_lo_d = result[31:0];
          cnt_d   = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          state_d = RUN;
        end else if (MDUop == 4'd5) begin
          hi_d = A;
        end else if (MDUop == 4'd6) begin
          lo_d = A;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_d    = sh_hi_q;
          lo_d    = sh_lo_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset wins over any op in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
    end
  end

endmodule
